// File: rtl/dct_seq_ctrl.sv
// dct_seq_ctrl: sequencing controller for the eight-coefficient DCT datapath.
// Accepts one 8-sample frame per in_valid/in_ready handshake and holds it on dct_x.
// Runs the datapath for COMP_CYCLES cycles, then captures all eight coefficients.
// Streams the coefficients in index order over out_valid/out_ready.
//
// Optional build macro DCT_SEQ_FRAME_CNT_EN adds a 16-bit wrapping count of completed
// frames on the frame_cnt port.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    frame handshake; in_data packs sample k at [k*IN_W +: IN_W]
//   dct_x                registered frame driven to all datapath instances
//   dct_en/dct_cs        datapath enable / ROM chip-select
//   dct_clr              accumulator clear
//   dct_y                datapath coefficients, word k at [k*OUT_W +: OUT_W]
//   out_valid/out_ready  coefficient stream handshake
//   out_data/out_idx     coefficient value and its index
//   out_last             marks index 7
//   busy                 controller not idle
//   frame_cnt            completed-frame count (DCT_SEQ_FRAME_CNT_EN only)
module dct_seq_ctrl #(
  parameter int unsigned COMP_CYCLES = 10,
  parameter int unsigned IN_W        = 8,
  parameter int unsigned OUT_W       = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*IN_W-1:0]    in_data,
  output logic [8*IN_W-1:0]    dct_x,
  output logic                 dct_en,
  output logic                 dct_cs,
  output logic                 dct_clr,
  input  logic [8*OUT_W-1:0]   dct_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [2:0]           out_idx,
  output logic                 out_last,
  output logic                 busy
`ifdef DCT_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  if (COMP_CYCLES < 1 || COMP_CYCLES > 255) begin : g_bad_comp_cycles
    $error("dct_seq_ctrl: COMP_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CntLast = 8'(COMP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCompute,
    StCapture,
    StDrain
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q;
  logic [2:0]         idx_q;
  logic [OUT_W-1:0]   coef_q [8];
  logic               accept_last;

  assign accept_last = (state_q == StDrain) && out_ready && (idx_q == 3'd7);

  // Outputs decode directly from the state register, so a reset edge clears them at once.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    dct_en    = 1'b0;
    dct_cs    = 1'b0;
    dct_clr   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = 3'd0;
    out_last  = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = StLoad;
      end
      StLoad: begin
        dct_clr = 1'b1;
        dct_cs  = 1'b1;
        state_d = StCompute;
      end
      StCompute: begin
        dct_en = 1'b1;
        dct_cs = 1'b1;
        if (cnt_q == CntLast) state_d = StCapture;
      end
      StCapture: begin
        state_d = StDrain;
      end
      StDrain: begin
        out_valid = 1'b1;
        out_data  = coef_q[idx_q];
        out_idx   = idx_q;
        out_last  = (idx_q == 3'd7);
        if (accept_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dct_x   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int k = 0; k < 8; k++) coef_q[k] <= '0;
    end else begin
      state_q <= state_d;
      // The frame register only loads on the handshake, so it is frozen for the whole
      // compute window and a frame offered while busy cannot overwrite it.
      if (state_q == StIdle && in_valid) dct_x <= in_data;
      if (state_q == StLoad) cnt_q <= '0;
      if (state_q == StCompute) cnt_q <= cnt_q + 8'd1;
      if (state_q == StCapture) begin
        for (int k = 0; k < 8; k++) coef_q[k] <= dct_y[k*OUT_W +: OUT_W];
        idx_q <= 3'd0;
      end
      if (state_q == StDrain && out_ready) idx_q <= idx_q + 3'd1;
    end
  end

`ifdef DCT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (accept_last) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_dct_seq_ctrl.sv
// Self-checking bench for dct_seq_ctrl: directed and randomized frames against a
// timeline model computed from the handshake cycle.
module tb_dct_seq_ctrl;
  localparam int C     = 10;
  localparam int IN_W  = 8;
  localparam int OUT_W = 19;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [8*IN_W-1:0]   in_data;
  logic [8*IN_W-1:0]   dct_x;
  logic                dct_en, dct_cs, dct_clr;
  logic [8*OUT_W-1:0]  dct_y;
  logic                out_valid, out_ready;
  logic [OUT_W-1:0]    out_data;
  logic [2:0]          out_idx;
  logic                out_last;
  logic                busy;
`ifdef DCT_SEQ_FRAME_CNT_EN
  logic [15:0]         frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dct_seq_ctrl #(.COMP_CYCLES(C), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dct_x     (dct_x),
    .dct_en    (dct_en),
    .dct_cs    (dct_cs),
    .dct_clr   (dct_clr),
    .dct_y     (dct_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
`ifdef DCT_SEQ_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  function automatic logic [8*IN_W-1:0] rand_frame();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [8*OUT_W-1:0] rand_coefs();
    logic [8*OUT_W-1:0] v;
    for (int k = 0; k < 8; k++) v[k*OUT_W +: OUT_W] = OUT_W'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; dct_y = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, dct_en, dct_cs, dct_clr, out_valid, out_last, busy} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want %b",
               {in_ready, dct_en, dct_cs, dct_clr, out_valid, out_last, busy}, 7'b1000000);
    end
    checks++;
    if (out_idx !== 3'd0 || out_data !== '0 || dct_x !== '0) begin
      errors++;
      $display("FAIL reset_data got idx=%0d data=%0h x=%0h want 0", out_idx, out_data, dct_x);
    end
`ifdef DCT_SEQ_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got %0h want 0", frame_cnt);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One frame from offer to final acceptance. mode: 0 ready always high, 1 five-cycle
  // stall at idx 3, 2 random ready. waits returns negedges spent before in_ready.
  task automatic run_frame(input logic [8*IN_W-1:0] x, input logic [8*OUT_W-1:0] y,
                           input int mode, input logic [8*IN_W-1:0] nx, input bit have_next,
                           output int waits);
    int k, exp_idx, stall, hold3;
    logic [6:0] exp_c;
    in_data = x; in_valid = 1'b1; out_ready = 1'b0; waits = 0;
    while (in_ready !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) begin
      checks++; errors++;
      $display("FAIL handshake_timeout got in_ready=%b want 1", in_ready);
      return;
    end
    @(negedge clk);
    k = 1;
    in_valid = have_next;
    in_data  = have_next ? nx : rand_frame();
    exp_idx = 0; stall = 0; hold3 = 0;
    while (exp_idx < 8 && k < C + 200) begin
      // {in_ready, dct_en, dct_cs, dct_clr, out_valid, out_last, busy}
      if (k == 1)           exp_c = 7'b0011001;
      else if (k <= C + 1)  exp_c = 7'b0110001;
      else if (k == C + 2)  exp_c = 7'b0000001;
      else                  exp_c = {4'b0000, 1'b1, exp_idx == 7, 1'b1};
      checks++;
      if ({in_ready, dct_en, dct_cs, dct_clr, out_valid, out_last, busy} !== exp_c) begin
        errors++;
        $display("FAIL ctrl k=%0d got %b want %b", k,
                 {in_ready, dct_en, dct_cs, dct_clr, out_valid, out_last, busy}, exp_c);
      end
      checks++;
      if (dct_x !== x) begin
        errors++;
        $display("FAIL dct_x_hold k=%0d got %0h want %0h", k, dct_x, x);
      end
      // Correct coefficients are present only around the capture edge.
      if (k < C + 2)       dct_y = rand_coefs();
      else if (k == C + 2) dct_y = y;
      else if (k == C + 3) dct_y = {8{19'h7FFFF}};
      if (k >= C + 3) begin
        checks++;
        if (out_idx !== 3'(exp_idx) || out_data !== y[exp_idx*OUT_W +: OUT_W]) begin
          errors++;
          $display("FAIL stream k=%0d got idx=%0d data=%0h want idx=%0d data=%0h", k,
                   out_idx, out_data, exp_idx, y[exp_idx*OUT_W +: OUT_W]);
        end
        if (exp_idx == 3) hold3++;
        case (mode)
          0: out_ready = 1'b1;
          1: if (exp_idx == 3 && stall < 5) begin out_ready = 1'b0; stall++; end
             else out_ready = 1'b1;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_ready) exp_idx++;
      end
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    checks++;
    if (exp_idx != 8) begin
      errors++;
      $display("FAIL drain_timeout got %0d accepted want 8", exp_idx);
    end
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL post_frame got %b want 100", {in_ready, out_valid, busy});
    end
    if (mode == 1) begin
      checks++;
      if (hold3 != 6) begin
        errors++;
        $display("FAIL stall_hold got %0d cycles want 6", hold3);
      end
    end
  endtask

  task automatic test_single();
    logic [8*IN_W-1:0] x;
    logic [8*OUT_W-1:0] y;
    int w;
    for (int k = 0; k < 8; k++) begin
      x[k*IN_W +: IN_W]   = IN_W'(k);
      y[k*OUT_W +: OUT_W] = OUT_W'(1000 + k);
    end
    run_frame(x, y, 0, '0, 1'b0, w);
  endtask

  task automatic test_backpressure();
    logic [8*OUT_W-1:0] y;
    int w;
    for (int k = 0; k < 8; k++) y[k*OUT_W +: OUT_W] = OUT_W'(1000 + k);
    run_frame(rand_frame(), y, 1, '0, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    logic [8*IN_W-1:0] x1, x2;
    int w1, w2;
    x1 = rand_frame();
    x2 = rand_frame();
    run_frame(x1, rand_coefs(), 0, x2, 1'b1, w1);
    run_frame(x2, rand_coefs(), 0, '0, 1'b0, w2);
    checks++;
    if (w2 != 0) begin
      errors++;
      $display("FAIL back_to_back_gap got %0d extra cycles want 0", w2);
    end
  endtask

  task automatic test_reset_abort();
    int waits, seen;
    in_data = rand_frame(); in_valid = 1'b1; waits = 0;
    while (in_ready !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    // Sixth cycle after the handshake is the fourth compute count.
    checks++;
    if (dct_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_compute got dct_en=%b want 1", dct_en);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, dct_en, dct_cs, dct_clr, out_valid, busy} !== 6'b100000) begin
      errors++;
      $display("FAIL abort_idle got %b want 100000",
               {in_ready, dct_en, dct_cs, dct_clr, out_valid, busy});
    end
    in_valid = 1'b1; in_data = rand_frame();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || dct_x !== '0) begin
      errors++;
      $display("FAIL reset_wins got busy=%b in_ready=%b x=%0h want 0 1 0", busy, in_ready, dct_x);
    end
    rst = 1'b0; in_valid = 1'b0; seen = 0;
    repeat (C + 15) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_output got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 4; n++) run_frame(rand_frame(), rand_coefs(), 2, '0, 1'b0, w);
  endtask

`ifdef DCT_SEQ_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int w;
    dut.frame_cnt_q = 16'hFFFE;
    run_frame(rand_frame(), rand_coefs(), 0, '0, 1'b0, w);
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL frame_cnt_ffff got %0h want ffff", frame_cnt);
    end
    run_frame(rand_frame(), rand_coefs(), 0, '0, 1'b0, w);
    checks++;
    if (frame_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL frame_cnt_wrap got %0h want 0", frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef DCT_SEQ_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
